// File: rtl/score_keeper.sv
// Two-player match scoring FSM: edge-detected hits become 5-bit scores, with win/draw detection.
// Optional per-player hit lockout (frame_tick based) is enabled by defining HIT_LOCKOUT_EN.
module score_keeper #(
  parameter int WIN_SCORE      = 10,
  parameter int LOCKOUT_FRAMES = 30,
  parameter int LOCK_W         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [4:0] score_p1,
  output logic [4:0] score_p2,
  output logic       score_evt,
  output logic       game_active,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [4:0] WIN = 5'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       hit1_prev_q, hit2_prev_q;
  logic [4:0] score1_q, score1_d;
  logic [4:0] score2_q, score2_d;
  logic       evt_q, evt_d;
  logic [1:0] winner_q, winner_d;
  logic       open1, open2;
  logic       cnt1, cnt2;

  // A start in the same cycle as a hit discards the hit.
  assign cnt1 = (state_q == PLAY) && !start && hit_p1 && !hit1_prev_q && open1;
  assign cnt2 = (state_q == PLAY) && !start && hit_p2 && !hit2_prev_q && open2;

`ifdef HIT_LOCKOUT_EN
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_FRAMES);

  logic [LOCK_W-1:0] lock1_q, lock1_d;
  logic [LOCK_W-1:0] lock2_q, lock2_d;

  assign open1 = (lock1_q == '0);
  assign open2 = (lock2_q == '0);

  always_comb begin
    lock1_d = lock1_q;
    lock2_d = lock2_q;
    if (frame_tick && lock1_q != '0) lock1_d = lock1_q - 1'b1;
    if (frame_tick && lock2_q != '0) lock2_d = lock2_q - 1'b1;
    if (cnt1) lock1_d = LOCK_LOAD;
    if (cnt2) lock2_d = LOCK_LOAD;
    if (start) begin
      lock1_d = '0;
      lock2_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock1_q <= '0;
      lock2_q <= '0;
    end else begin
      lock1_q <= lock1_d;
      lock2_q <= lock2_d;
    end
  end
`else
  logic unused_in;

  assign open1     = 1'b1;
  assign open2     = 1'b1;
  assign unused_in = frame_tick ^ (LOCKOUT_FRAMES > 0) ^ (LOCK_W > 0);
`endif

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    evt_d    = 1'b0;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PLAY;
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'b00;
        end
      end
      PLAY: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'b00;
        end else begin
          if (cnt1) score1_d = score1_q + 5'd1;
          if (cnt2) score2_d = score2_q + 5'd1;
          evt_d = cnt1 | cnt2;
          // Both reaching WIN on the same edge encodes as 2'b11 (draw).
          if (score1_d == WIN || score2_d == WIN) begin
            state_d  = OVER;
            winner_d = {score2_d == WIN, score1_d == WIN};
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d  = PLAY;
          score1_d = '0;
          score2_d = '0;
          winner_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hit1_prev_q <= 1'b0;
      hit2_prev_q <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      evt_q       <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      hit1_prev_q <= hit_p1;
      hit2_prev_q <= hit_p2;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      evt_q       <= evt_d;
      winner_q    <= winner_d;
    end
  end

  assign score_p1    = score1_q;
  assign score_p2    = score2_q;
  assign score_evt   = evt_q;
  assign winner      = winner_q;
  assign game_active = (state_q == PLAY);
  assign game_over   = (state_q == OVER);

endmodule
